// File: rtl/dma_pkg.sv
// Shared types and AXI constants for the DMA burst writer.
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } dma_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/dma_burst_writer_fifo.sv
// First-word-fall-through FIFO with registered count/full; flush empties it.
module sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 64,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]         count,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  wr_en, rd_en;
  logic [CW-1:0]         count_nxt;

  assign wr_en     = push && !full;
  assign rd_en     = pop && (count != '0);
  assign count_nxt = count + CW'(wr_en) - CW'(rd_en);
  assign dout      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dma_burst_writer.sv
// AXI3 write master: buffers a stream and drains it as fixed INCR bursts.
// Ring-buffer capture is compiled in with DMA_RING_EN.
module dma_burst_writer
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_WIDTH  = 20
) (
  input  logic                    aclk,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [LEN_WIDTH-1:0]    len_beats_i,
  input  logic                    ring_i,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  output logic [3:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic                    m_axi_bvalid,
  input  logic [1:0]              m_axi_bresp,
  output logic                    m_axi_bready,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [LEN_WIDTH-1:0]    beats_written_o,
  output logic [15:0]             wrap_cnt_o
);

  localparam int CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int BURST_BYTES = BURST_LEN * (DATA_WIDTH / 8);
  localparam int ALIGN_BITS  = $clog2(BURST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~((ADDR_WIDTH'(1) << ALIGN_BITS) - ADDR_WIDTH'(1));
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP   = ADDR_WIDTH'(BURST_BYTES);
  localparam logic [LEN_WIDTH-1:0]  BURST_BEATS = LEN_WIDTH'(BURST_LEN);

  dma_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] base_q, ptr_q;
  logic [LEN_WIDTH-1:0]  bursts_left, len_bursts, reload_len;
  logic [3:0]            beat_cnt;
  logic                  stop_pend, stop_seen, ring_wrap, last_burst;
  logic                  start_ok, w_hs, resp_hs;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;

  assign len_bursts = len_beats_i / BURST_BEATS;
  assign start_ok   = start_i && (state == ST_IDLE || state == ST_DONE);
  assign stop_seen  = stop_pend || stop_i;
  assign last_burst = (bursts_left == LEN_WIDTH'(1));
  assign w_hs       = m_axi_wvalid && m_axi_wready;
  assign resp_hs    = (state == ST_RESP) && m_axi_bvalid;

  assign busy_o        = (state != ST_IDLE) && (state != ST_DONE);
  assign done_o        = (state == ST_DONE);
  assign s_ready_o     = busy_o && !fifo_full;
  assign m_axi_awvalid = (state == ST_ADDR);
  assign m_axi_awaddr  = ptr_q;
  assign m_axi_awlen   = 4'(BURST_LEN - 1);
  assign m_axi_awsize  = axi_size(DATA_WIDTH);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wvalid  = (state == ST_DATA);
  assign m_axi_wdata   = m_axi_wvalid ? fifo_dout : '0;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = m_axi_wvalid && (beat_cnt == 4'(BURST_LEN - 1));
  assign m_axi_bready  = (state == ST_RESP);

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (aclk),
    .rst   (rst_i),
    .flush (start_ok),
    .push  (s_valid_i && s_ready_o),
    .din   (s_data_i),
    .pop   (w_hs),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start_i) state_nxt = (len_bursts == '0) ? ST_DONE : ST_FILL;
      // A burst is only announced once every beat of it sits in the FIFO.
      ST_FILL: begin
        if (stop_seen)                        state_nxt = ST_DONE;
        else if (fifo_count >= CW'(BURST_LEN)) state_nxt = ST_ADDR;
      end
      ST_ADDR: if (m_axi_awready) state_nxt = ST_DATA;
      ST_DATA: if (w_hs && m_axi_wlast) state_nxt = ST_RESP;
      ST_RESP: begin
        if (m_axi_bvalid) begin
          if (stop_seen || (last_burst && !ring_wrap)) state_nxt = ST_DONE;
          else                                         state_nxt = ST_FILL;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst_i) begin
      state           <= ST_IDLE;
      base_q          <= '0;
      ptr_q           <= '0;
      bursts_left     <= '0;
      beat_cnt        <= '0;
      stop_pend       <= 1'b0;
      err_o           <= 1'b0;
      beats_written_o <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        base_q          <= base_addr_i & ALIGN_MASK;
        ptr_q           <= base_addr_i & ALIGN_MASK;
        bursts_left     <= len_bursts;
        beat_cnt        <= '0;
        stop_pend       <= stop_i;
        err_o           <= 1'b0;
        beats_written_o <= '0;
      end else begin
        if (busy_o && stop_i) stop_pend <= 1'b1;
        if (w_hs) begin
          beats_written_o <= beats_written_o + 1'b1;
          beat_cnt        <= m_axi_wlast ? 4'd0 : beat_cnt + 4'd1;
        end
        if (resp_hs) begin
          if (m_axi_bresp != AXI_RESP_OKAY) err_o <= 1'b1;
          if (last_burst && ring_wrap) begin
            ptr_q       <= base_q;
            bursts_left <= reload_len;
          end else begin
            ptr_q       <= ptr_q + ADDR_STEP;
            bursts_left <= bursts_left - 1'b1;
          end
        end
      end
    end
  end

`ifdef DMA_RING_EN
  logic                 ring_q;
  logic [LEN_WIDTH-1:0] bursts_total;
  logic [15:0]          wrap_q;

  always_ff @(posedge aclk) begin
    if (rst_i) begin
      ring_q       <= 1'b0;
      bursts_total <= '0;
      wrap_q       <= '0;
    end else if (start_ok) begin
      ring_q       <= ring_i;
      bursts_total <= len_bursts;
      wrap_q       <= '0;
    end else if (resp_hs && last_burst && ring_q && wrap_q != 16'hFFFF) begin
      wrap_q <= wrap_q + 16'd1;
    end
  end

  assign ring_wrap  = ring_q;
  assign reload_len = bursts_total;
  assign wrap_cnt_o = wrap_q;
`else
  logic unused_ring;
  assign unused_ring = ring_i;
  assign ring_wrap   = 1'b0;
  assign reload_len  = '0;
  assign wrap_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_dma_burst_writer.sv
// Randomised bench for dma_burst_writer: AXI slave + stream source, checked
// against a queue model of stream order and burst addressing.
module tb_dma_burst_writer;
  localparam int DW = 64, AW = 32, LW = 20, BL = 16, BB = 128;

  logic          aclk = 1'b0;
  logic          rst_i, start_i, stop_i, ring_i;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] len_beats_i;
  logic [DW-1:0] s_data_i;
  logic          s_valid_i, s_ready_o;
  logic [AW-1:0] m_axi_awaddr;
  logic          m_axi_awvalid, m_axi_awready;
  logic [3:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [1:0]    m_axi_awburst;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic          m_axi_bvalid, m_axi_bready;
  logic [1:0]    m_axi_bresp;
  logic          busy_o, done_o, err_o;
  logic [LW-1:0] beats_written_o;
  logic [15:0]   wrap_cnt_o;

  dma_burst_writer dut (
    .aclk(aclk), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .base_addr_i(base_addr_i), .len_beats_i(len_beats_i), .ring_i(ring_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .beats_written_o(beats_written_o), .wrap_cnt_o(wrap_cnt_o)
  );

  always #5 aclk = ~aclk;

  int checks = 0, failures = 0;
  int stall_pct = 0, push_limit = 0, err_burst = -1;
  bit stream_en = 1'b0;

  logic [DW-1:0] push_q[$], w_q[$];
  logic [AW-1:0] aw_q[$];
  bit            wl_q[$];
  int  push_cnt, aw_cnt, wl_cnt, b_cnt, bubbles, ost_viol;
  bit  in_burst;

  // Observe handshakes half a cycle before the edge that completes them.
  always @(negedge aclk) begin
    if (s_valid_i && s_ready_o) begin push_q.push_back(s_data_i); push_cnt++; end
    if (m_axi_awvalid && m_axi_awready) begin
      aw_q.push_back(m_axi_awaddr);
      if (aw_cnt != b_cnt) ost_viol++;
      aw_cnt++;
    end
    if (in_burst && !m_axi_wvalid) bubbles++;
    if (m_axi_wvalid && m_axi_wready) begin
      w_q.push_back(m_axi_wdata);
      wl_q.push_back(m_axi_wlast);
      if (m_axi_wlast) wl_cnt++;
    end
    if (m_axi_wvalid && m_axi_wready && m_axi_wlast) in_burst = 1'b0;
    else if (m_axi_wvalid) in_burst = 1'b1;
    if (m_axi_bvalid && m_axi_bready) b_cnt++;
  end

  // AXI slave and stream source.
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    s_valid_i = 0; s_data_i = '0;
    forever begin
      @(posedge aclk); #1;
      m_axi_awready = ($urandom_range(99) >= stall_pct);
      m_axi_wready  = ($urandom_range(99) >= stall_pct);
      if (wl_cnt > b_cnt && (m_axi_bvalid || $urandom_range(99) >= stall_pct)) begin
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      end else begin
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
      end
      s_valid_i = stream_en && (push_cnt < push_limit);
      s_data_i  = {$urandom, $urandom};
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic start_xfer(input logic [AW-1:0] base, input int len, input bit ring, input bit stp);
    push_q.delete(); w_q.delete(); aw_q.delete(); wl_q.delete();
    push_cnt = 0; aw_cnt = 0; wl_cnt = 0; b_cnt = 0; bubbles = 0; ost_viol = 0; in_burst = 0;
    base_addr_i = base; len_beats_i = LW'(len); ring_i = ring;
    start_i = 1'b1; stop_i = stp;
    cycles(1);
    start_i = 1'b0; stop_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done_o && n < budget) begin cycles(1); n++; end
    if (!done_o) begin
      checks++; failures++;
      $display("FAIL %s timeout: done_o=%0b required 1 within %0d cycles", name, done_o, budget);
    end
  endtask

  // Model: W carries the stream in arrival order, wlast on every BL-th beat.
  function automatic int data_errs(input int n);
    int e = 0;
    if (w_q.size() != n) e++;
    for (int i = 0; i < w_q.size(); i++) begin
      if (i >= push_q.size() || w_q[i] !== push_q[i]) e++;
      if (wl_q[i] != ((i % BL) == BL - 1)) e++;
    end
    return e;
  endfunction

  // Model: burst k targets aligned base + (k mod nb) * burst bytes.
  function automatic int addr_errs(input logic [AW-1:0] base, input int nb);
    int e = 0;
    logic [AW-1:0] al = base & ~AW'(BB - 1);
    for (int i = 0; i < aw_q.size(); i++)
      if (aw_q[i] !== al + AW'((i % nb) * BB)) e++;
    return e;
  endfunction

  task automatic test_reset();
    logic [DW+AW+LW+16+7:0] zeros;
    rst_i = 1'b1; start_i = 0; stop_i = 0; ring_i = 0;
    base_addr_i = '0; len_beats_i = '0;
    cycles(3);
    zeros = {busy_o, done_o, err_o, s_ready_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
             m_axi_wlast, beats_written_o, wrap_cnt_o, m_axi_awaddr, m_axi_wdata};
    checks++; if (zeros !== '0) begin failures++;
      $display("FAIL reset_outputs got %h required 0", zeros); end
    checks++; if (m_axi_awburst !== 2'b01) begin failures++;
      $display("FAIL reset_awburst got %b required 01", m_axi_awburst); end
    checks++; if ({m_axi_awlen, m_axi_awsize} !== {4'd15, 3'd3}) begin failures++;
      $display("FAIL awlen_awsize got %0d/%0d required 15/3", m_axi_awlen, m_axi_awsize); end
    checks++; if (m_axi_wstrb !== 8'hFF) begin failures++;
      $display("FAIL wstrb got %h required ff", m_axi_wstrb); end
    rst_i = 1'b0;
    cycles(1);
  endtask

  task automatic test_basic();
    stall_pct = 0; stream_en = 1; push_limit = 1000;
    start_xfer(32'h1000_0000, 32, 0, 0);
    wait_done("basic", 2000);
    checks++; if (aw_q.size() != 2 || aw_q[0] !== 32'h1000_0000 || aw_q[1] !== 32'h1000_0080) begin
      failures++; $display("FAIL basic_aw got %0d bursts required 2 at 10000000/10000080", aw_q.size()); end
    checks++; if (data_errs(32) != 0) begin failures++;
      $display("FAIL basic_data got %0d errors required 0", data_errs(32)); end
    checks++; if ({done_o, err_o, beats_written_o} !== {1'b1, 1'b0, LW'(32)}) begin failures++;
      $display("FAIL basic_status got done=%0b err=%0b beats=%0d required 1/0/32", done_o, err_o, beats_written_o); end
  endtask

  task automatic test_stall();
    stall_pct = 50; stream_en = 1; push_limit = 1000;
    start_xfer(32'h2000_0045, 50, 0, 0);
    wait_done("stall", 5000);
    checks++; if (beats_written_o !== LW'(48)) begin failures++;
      $display("FAIL stall_beats got %0d required 48", beats_written_o); end
    checks++; if (aw_q.size() != 3 || addr_errs(32'h2000_0045, 3) != 0) begin failures++;
      $display("FAIL stall_aw got %0d bursts, %0d bad addrs required 3/0", aw_q.size(), addr_errs(32'h2000_0045, 3)); end
    checks++; if (data_errs(48) != 0) begin failures++;
      $display("FAIL stall_data got %0d errors required 0", data_errs(48)); end
    checks++; if (bubbles != 0 || ost_viol != 0) begin failures++;
      $display("FAIL stall_protocol got bubbles=%0d overlap=%0d required 0/0", bubbles, ost_viol); end
    stall_pct = 0;
  endtask

  task automatic test_stream_gap();
    stream_en = 1; push_limit = 20;
    start_xfer(32'h3000_0000, 64, 0, 0);
    cycles(150);
    checks++; if ({busy_o, beats_written_o} !== {1'b1, LW'(16)} || aw_q.size() != 1) begin failures++;
      $display("FAIL gap_hold got busy=%0b beats=%0d aw=%0d required 1/16/1", busy_o, beats_written_o, aw_q.size()); end
    push_limit = 1000;
    wait_done("gap", 2000);
    checks++; if (beats_written_o !== LW'(64) || data_errs(64) != 0) begin failures++;
      $display("FAIL gap_resume got beats=%0d errors=%0d required 64/0", beats_written_o, data_errs(64)); end
  endtask

  task automatic test_bresp_err();
    stall_pct = 20; err_burst = 1; push_limit = 1000;
    start_xfer(32'h0800_0000, 32, 0, 0);
    wait_done("bresp", 3000);
    cycles(3);
    checks++; if ({err_o, done_o, beats_written_o} !== {1'b1, 1'b1, LW'(32)}) begin failures++;
      $display("FAIL bresp_sticky got err=%0b done=%0b beats=%0d required 1/1/32", err_o, done_o, beats_written_o); end
    err_burst = -1;
    start_xfer(32'h0800_0000, 16, 0, 0);
    checks++; if (err_o !== 1'b0 || busy_o !== 1'b1) begin failures++;
      $display("FAIL bresp_clear got err=%0b busy=%0b required 0/1", err_o, busy_o); end
    wait_done("bresp2", 2000);
    checks++; if (err_o !== 1'b0 || beats_written_o !== LW'(16)) begin failures++;
      $display("FAIL bresp_clean got err=%0b beats=%0d required 0/16", err_o, beats_written_o); end
    stall_pct = 0;
  endtask

  task automatic test_stop();
    int n = 0;
    push_limit = 1000;
    start_xfer(32'h0400_0000, 64, 0, 0);
    while (beats_written_o < LW'(20) && n < 500) begin cycles(1); n++; end
    stop_i = 1'b1; cycles(1); stop_i = 1'b0;
    wait_done("stop", 2000);
    checks++; if (beats_written_o !== LW'(32) || aw_q.size() != 2) begin failures++;
      $display("FAIL stop_mid got beats=%0d aw=%0d required 32/2", beats_written_o, aw_q.size()); end
    checks++; if (data_errs(32) != 0) begin failures++;
      $display("FAIL stop_data got %0d errors required 0", data_errs(32)); end
  endtask

  task automatic test_start_stop();
    start_xfer(32'h0400_0000, 64, 0, 1);
    wait_done("start_stop", 100);
    cycles(5);
    checks++; if (beats_written_o !== '0 || aw_q.size() != 0 || done_o !== 1'b1) begin failures++;
      $display("FAIL start_stop got beats=%0d aw=%0d done=%0b required 0/0/1", beats_written_o, aw_q.size(), done_o); end
  endtask

  task automatic test_zero_len();
    start_xfer(32'h0400_0000, BL - 1, 0, 0);
    checks++; if ({done_o, busy_o} !== 2'b10) begin failures++;
      $display("FAIL zero_len got done=%0b busy=%0b required 1/0", done_o, busy_o); end
    cycles(10);
    checks++; if (aw_q.size() != 0 || beats_written_o !== '0) begin failures++;
      $display("FAIL zero_len_idle got aw=%0d beats=%0d required 0/0", aw_q.size(), beats_written_o); end
  endtask

  task automatic test_ring();
`ifdef DMA_RING_EN
    int n = 0;
    push_limit = 100000;
    start_xfer(32'h5000_0000, 32, 1, 0);
    while (aw_cnt < 3 && n < 2000) begin cycles(1); n++; end
    checks++; if (aw_q.size() < 3 || aw_q[2] !== 32'h5000_0000 || wrap_cnt_o !== 16'd1) begin failures++;
      $display("FAIL ring_wrap got aw=%0d wrap=%0d required >=3 bursts, third at base, wrap 1", aw_q.size(), wrap_cnt_o); end
    cycles(40);
    checks++; if (done_o !== 1'b0) begin failures++;
      $display("FAIL ring_running got done=%0b required 0", done_o); end
    stop_i = 1'b1; cycles(1); stop_i = 1'b0;
    wait_done("ring", 2000);
    checks++; if (addr_errs(32'h5000_0000, 2) != 0 || data_errs(aw_q.size() * BL) != 0) begin failures++;
      $display("FAIL ring_seq got addr_err=%0d data_err=%0d required 0/0", addr_errs(32'h5000_0000, 2), data_errs(aw_q.size() * BL)); end
`else
    push_limit = 1000;
    start_xfer(32'h5000_0000, 32, 1, 0);
    wait_done("oneshot", 2000);
    checks++; if (aw_q.size() != 2 || wrap_cnt_o !== '0 || beats_written_o !== LW'(32)) begin failures++;
      $display("FAIL oneshot got aw=%0d wrap=%0d beats=%0d required 2/0/32", aw_q.size(), wrap_cnt_o, beats_written_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_stream_gap();
    test_bresp_err();
    test_stop();
    test_start_stop();
    test_zero_len();
    test_ring();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_burst_writer.md
Name: dma_burst_writer

Overview:
Parametrised successor to the single-purpose DMA controller: an AXI3 write master that buffers a valid/ready sample stream in an internal FIFO and drains it to DDR through HP0 as fixed-length INCR bursts. It adds configurable data/address width, burst length, FIFO depth and transfer length, plus graceful stop, sticky BRESP error reporting and optional ring-buffer capture. It sits between the capture path (already in the aclk domain) and the PS HP0 slave port.

Parameters:
DATA_WIDTH, 64, stream and AXI W data width; must be 32 or 64.
ADDR_WIDTH, 32, AXI address width.
BURST_LEN, 16, beats per burst; range 1..16 (AXI3 limit).
FIFO_DEPTH, 64, FIFO entries; power of two, at least 2*BURST_LEN.
LEN_WIDTH, 20, width of the transfer-length and beat-count fields.

Ports:
aclk  in  1  clock for the whole block
rst_i  in  1  synchronous, active-high reset
start_i  in  1  one-cycle pulse; arms a transfer (ignored unless IDLE or DONE)
stop_i  in  1  pulse; finish the current burst, then go to DONE
base_addr_i  in  ADDR_WIDTH  DDR base; low log2(BURST_LEN*DATA_WIDTH/8) bits forced to 0
len_beats_i  in  LEN_WIDTH  transfer length in beats; rounded down to a BURST_LEN multiple
ring_i  in  1  ring mode request (honoured only with DMA_RING_EN)
s_data_i  in  DATA_WIDTH  stream data
s_valid_i  in  1  stream valid
s_ready_o  out  1  stream ready
m_axi_awaddr/awvalid/awlen[3:0]/awsize[2:0]/awburst[1:0]  out  -  AXI3 AW channel
m_axi_awready  in  1  AXI3 AW channel ready
m_axi_wdata/wstrb/wlast/wvalid  out  -  AXI3 W channel
m_axi_wready  in  1  AXI3 W channel ready
m_axi_bvalid  in  1  AXI3 B channel valid
m_axi_bresp  in  2  AXI3 B channel response
m_axi_bready  out  1  AXI3 B channel ready
busy_o  out  1  engaged: state not IDLE/DONE
done_o  out  1  level; held in DONE until the next start_i
err_o  out  1  sticky; set on any BRESP other than OKAY, cleared by start_i
beats_written_o  out  LEN_WIDTH  beats accepted by W since start (wraps)
wrap_cnt_o  out  16  ring wrap count

Behaviour:
- Reset: every output is 0, FSM=IDLE, FIFO empty, awburst=2'b01.
- Constant outputs: awlen=BURST_LEN-1; awsize=log2(DATA_WIDTH/8); wstrb all ones.
- States: IDLE -> (start_i) FILL -> ADDR -> DATA -> RESP -> FILL | DONE.
- start_i flushes the FIFO and latches base, length and ring. It clears the counters and err_o. The address pointer is set to base.
- If the rounded length is 0: go to DONE on the next cycle.
- s_ready_o = busy_o && !fifo_full. Stream data is dropped only by the upstream block; this block never overwrites FIFO entries.
- FILL: wait for fifo_count >= BURST_LEN, then ADDR. A burst always has its full data buffered before AW is issued, so W never has bubbles.
- ADDR: awvalid=1 until awready. Address = pointer. Go to DATA.
- DATA: wvalid=1 while beats remain. Pop the FIFO on wvalid&&wready. wlast on beat BURST_LEN-1.
- RESP: bready=1. On bvalid: err_o |= (bresp!=0). Pointer += BURST_LEN*DATA_WIDTH/8. Remaining -= BURST_LEN.
- After RESP: if remaining==0 or stop was pending, go to DONE; otherwise go to FILL.
- Only one burst is outstanding. AW is not issued again before B completes.
- stop_i is latched as pending in any busy state. In FILL it goes directly to DONE with no partial burst. In ADDR/DATA/RESP the burst completes first.
- Simultaneous start_i and stop_i in IDLE: start_i wins and stop is pending, so the block ends with DONE and no bursts.
- Bursts never cross 4 KB because base is aligned and the burst size is ≤128 B.
- rst_i mid-burst drops all valids on the next cycle. The HP0 port must be reset with it; software owns this.

Optional Feature:
- Macro DMA_RING_EN.
- With the macro: ring_i=1 makes the remaining count reach 0 wrap the pointer to base and reload the length. wrap_cnt_o increments (saturates at 0xFFFF). DONE is entered only via stop_i.
- Without the macro: ring_i is ignored, wrap_cnt_o is tied to 0, and the block is one-shot only.

Decomposition:
- Package dma_pkg holds:
  - the FSM state enum dma_state_t;
  - constants AXI_BURST_INCR=2'b01 and AXI_RESP_OKAY=2'b00;
  - a function computing awsize from DATA_WIDTH.
- Sub-module sync_fifo (DATA_WIDTH, FIFO_DEPTH) provides a count output. It has registered outputs and first-word fall-through.

Test Plan:
- base=0x1000_0000, len=32, stream always valid, awready/wready always 1 -> two bursts at 0x1000_0000 and 0x1000_0080, awlen=15, awsize=3, 32 beats with data in order, done_o=1, err_o=0.
- Random wready/awready/bvalid stall (50%) with len=48 -> no W bubble once a burst starts, wlast on every 16th beat, beats_written_o=48.
- s_valid_i held 0 after 20 beats with len=64 -> block waits in FILL after burst 1; on stream resume it completes 64 beats.
- Second burst gets BRESP=2'b10 -> err_o=1 and stays set, transfer still completes; the next start_i clears err_o.
- stop_i mid-DATA of burst 2, len=64 -> burst 2 completes, no third AW, done_o=1, beats_written_o=32.
- DMA_RING_EN, ring_i=1, len=32 -> the third burst addresses base, wrap_cnt_o=1; stop_i ends the transfer in DONE.
